// File: rtl/my_addsub_pkg.sv
// Shared types and default constants for the sequential slice-wise adder/subtractor.
package my_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

endpackage

// File: rtl/my_slice_adder.sv
// Combinational SLICE-bit ripple adder reused by every CALC cycle of my_seq_addsub.
module my_slice_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/my_seq_addsub.sv
// Sequential adder/subtractor: one SLICE-bit slice per cycle, LSB first.
// Define MY_SEQ_ADDSUB_SAT_EN to saturate on carry (add) or borrow (sub) instead of wrapping.
module my_seq_addsub
  import my_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t state, next_state;

  logic [WIDTH-1:0] a_r, b_r, acc, result, final_out;
  logic             sub_r, carry, final_cout, last, accept;
  logic [IDX_W-1:0] idx;
  logic [SLICE-1:0] s;
  logic             co;
  int               base;

  assign accept = start && (state != CALC);
  assign last   = (idx == IDX_W'(NSLICE - 1));
  assign base   = int'(idx) * SLICE;

  my_slice_adder #(.SLICE(SLICE)) u_slice (
    .x  (a_r[base +: SLICE]),
    .y  (b_r[base +: SLICE]),
    .cin(carry),
    .s  (s),
    .co (co)
  );

  always_comb begin
    result = acc;
    result[base +: SLICE] = s;
  end

  // Borrow is the complement of the final carry when b was inverted.
  assign final_cout = sub_r ? ~co : co;

`ifdef MY_SEQ_ADDSUB_SAT_EN
  assign final_out = final_cout ? (sub_r ? '0 : '1) : result;
`else
  assign final_out = result;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (last)  next_state = DONE;
      DONE:    next_state = start ? CALC : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      sub_r <= 1'b0;
      carry <= 1'b0;
      acc   <= '0;
      idx   <= '0;
      out   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= sub ? ~b : b;
      sub_r <= sub;
      carry <= sub;
      acc   <= '0;
      idx   <= '0;
    end else if (state == CALC) begin
      acc   <= result;
      carry <= co;
      idx   <= idx + IDX_W'(1);
      if (last) begin
        out  <= final_out;
        cout <= final_cout;
      end
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_my_seq_addsub.sv
// Scoreboard bench for my_seq_addsub: expected results are queued at start and checked on done.
module tb_my_seq_addsub;

  localparam int WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             cout;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, cout;
  logic [WIDTH-1:0] out;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   done_seen = 0;

  my_seq_addsub #(.WIDTH(WIDTH), .SLICE(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .out  (out),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    exp_t e;
    logic [WIDTH:0] full;
    if (s) begin
      e.cout = (x < y);
      e.out  = x - y;
    end else begin
      full   = {1'b0, x} + {1'b0, y};
      e.cout = full[WIDTH];
      e.out  = full[WIDTH-1:0];
    end
`ifdef MY_SEQ_ADDSUB_SAT_EN
    if (e.cout) e.out = s ? '0 : '1;
`endif
    return e;
  endfunction

  // Drives one start request; returns just after the edge that samples it.
  task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    a = x;
    b = y;
    sub = s;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(x, y, s));
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int exp_lat);
    int lat = 0;
    checkOutput({tag, "_busy_start"}, busy, 1);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      checkOutput({tag, "_busy_calc"}, busy, 1);
    end
    if (lat == 0) checkOutput({tag, "_done_timeout"}, done, 1);
    else begin
      checkOutput({tag, "_latency"}, lat, exp_lat);
      checkOutput({tag, "_busy_done"}, busy, 0);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", done, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("result_out", out, e.out);
        checkOutput("result_cout", cout, e.cout);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int seen_before;
    $display("[TB] starting");
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_out", out, 0);
    checkOutput("reset_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(16'd1024, 16'd1, 1'b0);
    waitDone("add_basic", 4);

    applyStimulus(16'd65535, 16'd1, 1'b0);
    waitDone("add_wrap", 4);

    applyStimulus(16'd1024, 16'd1024, 1'b1);
    waitDone("sub_equal", 4);

    applyStimulus(16'd1, 16'd1, 1'b0);
    a = 16'd100;
    b = 16'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("start_ignored", 3);

    applyStimulus(16'd3, 16'd4, 1'b0);
    waitDone("b2b_first", 4);
    applyStimulus(16'd1024, 16'd1024, 1'b0);
    waitDone("b2b_second", 4);

    applyStimulus(16'd5, 16'd7, 1'b1);
    waitDone("sub_borrow", 4);

    repeat (2) @(posedge clk);
    #1;
    applyStimulus(16'd1024, 16'd1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("midreset_out", out, 0);
    checkOutput("midreset_cout", cout, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    seen_before = done_seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("no_done_after_reset", done_seen - seen_before, 0);

    applyStimulus(16'd7, 16'd9, 1'b0);
    waitDone("post_reset_add", 4);

    repeat (2) @(posedge clk);
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/my_seq_addsub.md
MY_SEQ_ADDSUB -- requirements
Module: my_seq_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter SLICE, default 4, giving the bits processed per cycle; WIDTH SHALL be a multiple of SLICE.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: a request to begin an operation.
REQ-006 The block SHALL have port sub, input, 1 bit: 0 selects a+b, 1 selects a-b; it is sampled with start.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: unsigned operands, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port out, output, WIDTH bits: the result register.
REQ-011 The block SHALL have port cout, output, 1 bit: the carry (add) or borrow (sub) of the last operation.

Function
REQ-012 The FSM SHALL have three states:
- IDLE
- CALC
- DONE
REQ-013 In IDLE or DONE, start=1 at a rising edge SHALL latch a, b and sub, clear the slice index, and enter CALC.
REQ-014 start SHALL be ignored while in CALC; the latched operands SHALL NOT change.
REQ-015 CALC SHALL process one SLICE-bit slice per cycle, LSB slice first, with carry chained between slices.
- The initial carry-in SHALL be sub.
- Operand b SHALL be inverted when sub=1.
REQ-016 After WIDTH/SLICE CALC edges the FSM SHALL enter DONE. With the defaults, the start edge is k and DONE is entered at edge k+4.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle; the FSM SHALL return to IDLE at the next edge unless start=1, which starts a new operation back-to-back.
REQ-018 busy SHALL be 1 in CALC, and 0 in IDLE and DONE.
REQ-019 out and cout SHALL update only on entry to DONE, and SHALL hold their values until the next entry to DONE.
REQ-020 cout SHALL equal the final carry for add, and the inverted final carry (borrow) for sub.
REQ-021 Without saturation, the result SHALL wrap modulo 2^WIDTH. Example: 65535+1 gives out=0, cout=1.

Reset
REQ-022 rst_n=0 SHALL immediately, at any time including mid-CALC, force:
- state to IDLE
- busy=0 and done=0
- out=0 and cout=0
- the internal accumulator, carry and slice index to 0
REQ-023 After rst_n deasserts, the block SHALL accept start at the first rising edge.

Configuration
REQ-024 When macro MY_SEQ_ADDSUB_SAT_EN is defined, the result SHALL saturate:
- an add with cout=1 SHALL give out = all ones;
- a sub with cout=1 SHALL give out = 0;
- cout SHALL still report the carry or borrow.
REQ-025 When MY_SEQ_ADDSUB_SAT_EN is undefined, the block SHALL contain no saturation logic and SHALL wrap as in REQ-021.

Structure
REQ-026 Package my_addsub_pkg SHALL hold:
- the state enum type (IDLE, CALC, DONE);
- the default constants DEF_WIDTH=16 and DEF_SLICE=4.
REQ-027 A single combinational sub-module my_slice_adder SHALL implement the SLICE-bit add:
- inputs x, y and cin;
- outputs s and co;
- instantiated once and reused every CALC cycle.

Verification
REQ-028 The bench SHALL check: a=1024, b=1, sub=0, start at edge k -> busy during k+1..k+3, done=1 after edge k+4, out=1025, cout=0.
REQ-029 The bench SHALL check: a=65535, b=1, sub=0 -> without the macro, out=0 and cout=1; with the macro, out=65535 and cout=1.
REQ-030 The bench SHALL check: a=5, b=7, sub=1 -> without the macro, out=65534 and cout=1; with the macro, out=0 and cout=1. A second case, a=1024, b=1024, sub=1, SHALL give out=0 and cout=0.
REQ-031 The bench SHALL check: start a=1, b=1, then start again with a=100, b=100 while busy -> the second start is ignored; out=2.
REQ-032 The bench SHALL check: back-to-back start asserted during the done cycle with a=1024, b=1024 -> done again 4 cycles later with out=2048, and no IDLE cycle in between.
REQ-033 The bench SHALL check: rst_n pulsed low mid-CALC -> out=0, cout=0, busy=0 and done=0 immediately, and no done pulse follows.
